// File: rtl/motor_pkg.sv
// Shared command codes and sequencer state encoding for the LMD18245 command path.
package motor_pkg;

  localparam logic [1:0] CMD_FWD   = 2'd0;
  localparam logic [1:0] CMD_REV   = 2'd1;
  localparam logic [1:0] CMD_BRAKE = 2'd2;

  typedef enum logic [1:0] {ST_BRAKE, ST_FWD, ST_REV, ST_DWELL} state_t;

  // Request codes 2 and 3 both collapse to BRAKE.
  function automatic state_t cmd_to_state(input logic [1:0] cmd);
    case (cmd)
      CMD_FWD: cmd_to_state = ST_FWD;
      CMD_REV: cmd_to_state = ST_REV;
      default: cmd_to_state = ST_BRAKE;
    endcase
  endfunction

  function automatic logic [1:0] state_to_cmd(input state_t st);
    case (st)
      ST_FWD:  state_to_cmd = CMD_FWD;
      ST_REV:  state_to_cmd = CMD_REV;
      default: state_to_cmd = CMD_BRAKE;
    endcase
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter with a zero flag; shared between brake dwell and watchdog.
module cycle_timer #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    cnt_q <= '0;
    else if (clr)                  cnt_q <= '0;
    else if (load)                 cnt_q <= load_val;
    else if (dec && cnt_q != '0)   cnt_q <= cnt_q - 1'b1;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/motor_cmd_sequencer.sv
// Motor request sequencer: brake dwell before reversal, e-stop priority,
// optional stale-command watchdog enabled by defining MOTOR_WDOG_EN.
//
// state    | meaning
// ST_BRAKE | motor braked, waiting for FWD/REV
// ST_FWD   | driving forward
// ST_REV   | driving reverse
// ST_DWELL | forced brake before reversing into pend_q
module motor_cmd_sequencer
  import motor_pkg::*;
#(
  parameter int CNT_W        = 24,
  parameter int DWELL_CYCLES = 50000,
  parameter int WDOG_CYCLES  = 5000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [1:0] req_cmd,
  output logic       req_ready,
  input  logic       estop,
  output logic [1:0] cmd_out,
  output logic       running,
  output logic       fault_wdog
);

`ifdef MOTOR_WDOG_EN
  localparam bit WDOG_EN = 1'b1;
`else
  localparam bit WDOG_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] WDOG_LD  = CNT_W'(WDOG_CYCLES - 1);

  state_t           state_q, state_d, pend_q, pend_d, req_st;
  logic             fault_q, fault_d;
  logic [1:0]       cmd_q, cmd_d;
  logic             run_q, run_d;
  logic             accept;
  logic             t_clr, t_load, t_dec, t_zero;
  logic [CNT_W-1:0] t_val;

  assign req_ready = !estop && (state_q != ST_DWELL);
  assign accept    = req_valid && req_ready;
  assign req_st    = cmd_to_state(req_cmd);

  cycle_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (t_clr),
    .load     (t_load),
    .load_val (t_val),
    .dec      (t_dec),
    .zero     (t_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BRAKE;
      pend_q  <= ST_BRAKE;
      fault_q <= 1'b0;
      cmd_q   <= CMD_BRAKE;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      fault_q <= fault_d;
      cmd_q   <= cmd_d;
      run_q   <= run_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    fault_d = fault_q;
    t_clr   = 1'b0;
    t_load  = 1'b0;
    t_val   = DWELL_LD;
    t_dec   = 1'b0;
    if (estop) begin
      state_d = ST_BRAKE;
      pend_d  = ST_BRAKE;
      t_clr   = 1'b1;
    end else begin
      case (state_q)
        ST_BRAKE: if (accept) state_d = req_st;
        ST_FWD, ST_REV: begin
          t_dec = WDOG_EN;
          if (accept) begin
            if (req_st == ST_BRAKE || req_st == state_q) begin
              state_d = req_st;
            end else begin
              state_d = ST_DWELL;
              pend_d  = req_st;
            end
          end else if (WDOG_EN && t_zero) begin
            state_d = ST_BRAKE;
            fault_d = 1'b1;
          end
        end
        ST_DWELL: begin
          t_dec = 1'b1;
          if (t_zero) state_d = pend_q;
        end
        default: state_d = ST_BRAKE;
      endcase
      // A refresh or a fresh entry into a driving state re-arms the watchdog.
      if (state_d == ST_DWELL && state_q != ST_DWELL) begin
        t_load = 1'b1;
        t_val  = DWELL_LD;
      end else if (WDOG_EN && (state_d == ST_FWD || state_d == ST_REV) &&
                   (accept || state_d != state_q)) begin
        t_load = 1'b1;
        t_val  = WDOG_LD;
      end
      if (WDOG_EN && accept && req_st != ST_BRAKE) fault_d = 1'b0;
    end
  end

  always_comb begin
    cmd_d = state_to_cmd(state_d);
    run_d = (state_d == ST_FWD) || (state_d == ST_REV);
  end

  assign cmd_out    = cmd_q;
  assign running    = run_q;
  assign fault_wdog = fault_q;

endmodule
